clock_time_keeper: RTL and testbench

- Time-of-day counter directly upstream of the seven-segment display driver.
- Holds a 12-hour clock time as four BCD digits plus an AM/PM flag, advanced by a one-second prescaler.
- Supports a set mode in which time is frozen and hours/minutes are stepped by pre-debounced single-cycle pulses.
- Outputs feed the driver's digit3..digit0, am_Or_Pm and display_On inputs directly.

---
 rtl/clock_time_keeper.sv | 187 ++++++++++++++++++
 tb/tb_clock_time_keeper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clock_time_keeper.sv
// 12-hour BCD time-of-day keeper with one-second prescaler and set mode.
// Optional display blink in set mode is enabled with `define SET_BLINK_EN.
module clock_time_keeper #(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_Mode,
  input  logic       inc_Hour,
  input  logic       inc_Min,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       am_Or_Pm,
  output logic       second_Tick,
  output logic       display_On
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_HZ - 1);

  // Hour step {tens, units, pm}: 12 -> 01 keeps AM/PM, 11 -> 12 flips it.
  function automatic logic [8:0] hour_inc(input logic [3:0] tens,
                                          input logic [3:0] units,
                                          input logic       pm);
    logic [8:0] res;
    if ((tens == 4'd1) && (units == 4'd2)) begin
      res = {4'd0, 4'd1, pm};
    end else if ((tens == 4'd1) && (units == 4'd1)) begin
      res = {4'd1, 4'd2, ~pm};
    end else if (units == 4'd9) begin
      res = {4'd1, 4'd0, pm};
    end else begin
      res = {tens, units + 4'd1, pm};
    end
    return res;
  endfunction

  // Minute step {carry, tens, units}; carry is set on 59 -> 00.
  function automatic logic [8:0] min_inc(input logic [3:0] tens,
                                         input logic [3:0] units);
    logic [8:0] res;
    if (units == 4'd9) begin
      if (tens == 4'd5) begin
        res = {1'b1, 4'd0, 4'd0};
      end else begin
        res = {1'b0, tens + 4'd1, 4'd0};
      end
    end else begin
      res = {1'b0, tens, units + 4'd1};
    end
    return res;
  endfunction

  logic [PW-1:0] presc_r, presc_nx_s;
  logic [5:0]    sec_r, sec_nx_s;
  logic [3:0]    d3_r, d2_r, d1_r, d0_r;
  logic [3:0]    d3_nx_s, d2_nx_s, d1_nx_s, d0_nx_s;
  logic          pm_r, pm_nx_s;
  logic          tick_r, tick_nx_s;
  logic          wrap_s;
  logic [8:0]    hr_step_s;
  logic [8:0]    min_step_s;

  // Next-state for prescaler, seconds, BCD time and tick.
  always_comb begin
    wrap_s     = (presc_r == PRESC_MAX);
    hr_step_s  = hour_inc(d3_r, d2_r, pm_r);
    min_step_s = min_inc(d1_r, d0_r);
    presc_nx_s = presc_r;
    sec_nx_s   = sec_r;
    d3_nx_s    = d3_r;
    d2_nx_s    = d2_r;
    d1_nx_s    = d1_r;
    d0_nx_s    = d0_r;
    pm_nx_s    = pm_r;
    tick_nx_s  = 1'b0;
    if (set_Mode) begin
      presc_nx_s = '0;
      sec_nx_s   = 6'd0;
      if (inc_Min) begin
        d1_nx_s = min_step_s[7:4];
        d0_nx_s = min_step_s[3:0];
      end else begin
        d1_nx_s = d1_r;
        d0_nx_s = d0_r;
      end
      if (inc_Hour) begin
        {d3_nx_s, d2_nx_s, pm_nx_s} = hr_step_s;
      end else begin
        pm_nx_s = pm_r;
      end
    end else if (wrap_s) begin
      presc_nx_s = '0;
      tick_nx_s  = 1'b1;
      if (sec_r == 6'd59) begin
        sec_nx_s = 6'd0;
        d1_nx_s  = min_step_s[7:4];
        d0_nx_s  = min_step_s[3:0];
        // Seconds, minute and hour carries all land on this one edge.
        if (min_step_s[8]) begin
          {d3_nx_s, d2_nx_s, pm_nx_s} = hr_step_s;
        end else begin
          pm_nx_s = pm_r;
        end
      end else begin
        sec_nx_s = sec_r + 6'd1;
      end
    end else begin
      presc_nx_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Time-keeping state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
      sec_r   <= 6'd0;
      d3_r    <= 4'd1;
      d2_r    <= 4'd2;
      d1_r    <= 4'd0;
      d0_r    <= 4'd0;
      pm_r    <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_nx_s;
      sec_r   <= sec_nx_s;
      d3_r    <= d3_nx_s;
      d2_r    <= d2_nx_s;
      d1_r    <= d1_nx_s;
      d0_r    <= d0_nx_s;
      pm_r    <= pm_nx_s;
      tick_r  <= tick_nx_s;
    end
  end

  assign digit3      = d3_r;
  assign digit2      = d2_r;
  assign digit1      = d1_r;
  assign digit0      = d0_r;
  assign am_Or_Pm    = pm_r;
  assign second_Tick = tick_r;

`ifdef SET_BLINK_EN
  localparam int HALF = ((CLK_FREQ_HZ / 2) > 1) ? (CLK_FREQ_HZ / 2) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt_r, blink_cnt_nx_s;
  logic          blink_r, blink_nx_s;

  // Phase sits at 1 outside set mode, so entering set mode starts visible.
  always_comb begin
    blink_cnt_nx_s = blink_cnt_r;
    blink_nx_s     = blink_r;
    if (!set_Mode) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = 1'b1;
    end else if (inc_Hour || inc_Min) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = 1'b1;
    end else if (blink_cnt_r == BLINK_MAX) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = ~blink_r;
    end else begin
      blink_cnt_nx_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b1;
    end else begin
      blink_cnt_r <= blink_cnt_nx_s;
      blink_r     <= blink_nx_s;
    end
  end

  assign display_On = blink_r;
`else
  assign display_On = 1'b1;
`endif

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed self-checking bench for clock_time_keeper at CLK_FREQ_HZ=10.
module tb_clock_time_keeper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       set_Mode = 1'b0;
  logic       inc_Hour = 1'b0;
  logic       inc_Min = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       am_Or_Pm, second_Tick, display_On;

  int checks = 0;
  int failures = 0;
  int set_tick_cnt = 0;
  logic set_q = 1'b0;
  int t;
  int cyc;
  logic disp_hist [1:15];
  logic [15:0] hhmm;

  clock_time_keeper #(.CLK_FREQ_HZ(10)) dut (
    .clk(clk), .reset_n(reset_n), .set_Mode(set_Mode),
    .inc_Hour(inc_Hour), .inc_Min(inc_Min),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .am_Or_Pm(am_Or_Pm), .second_Tick(second_Tick), .display_On(display_On)
  );

  always #5 clk = ~clk;

  assign hhmm = {digit3, digit2, digit1, digit0};

  always @(posedge clk) set_q <= set_Mode;
  always @(negedge clk) if (set_q && second_Tick) set_tick_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic h, input logic m);
    inc_Hour = h;
    inc_Min  = m;
    @(negedge clk);
    inc_Hour = 1'b0;
    inc_Min  = 1'b0;
  endtask

  task automatic run_count(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (second_Tick) ticks++;
    end
  endtask

  task automatic first_tick(output int c);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (second_Tick) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_time", hhmm, 16'h1200);
    check_eq("rst_pm", am_Or_Pm, 1'b0);
    check_eq("rst_disp", display_On, 1'b1);
    check_eq("rst_tick", second_Tick, 1'b0);
    first_tick(cyc);
    check_eq("first_tick_cyc", cyc, 10);
    check_eq("first_tick_time", hhmm, 16'h1200);
    @(negedge clk);
    check_eq("tick_one_cycle", second_Tick, 1'b0);

    // 11:59 AM -> 12:00 PM
    set_Mode = 1'b1;
    @(negedge clk);
    repeat (11) pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    check_eq("preload_1159", hhmm, 16'h1159);
    check_eq("preload_am", am_Or_Pm, 1'b0);
    set_Mode = 1'b0;
    run_count(599, t);
    check_eq("ticks_599", t, 59);
    check_eq("pre_roll_1159", hhmm, 16'h1159);
    @(negedge clk);
    check_eq("roll_tick", second_Tick, 1'b1);
    check_eq("roll_1200", hhmm, 16'h1200);
    check_eq("roll_pm", am_Or_Pm, 1'b1);

    // 12:59 PM -> 01:00 PM
    set_Mode = 1'b1;
    @(negedge clk);
    repeat (59) pulse(1'b0, 1'b1);
    check_eq("preload_1259", hhmm, 16'h1259);
    set_Mode = 1'b0;
    run_count(600, t);
    check_eq("ticks_600", t, 60);
    check_eq("roll_0100", hhmm, 16'h0100);
    check_eq("roll_pm_kept", am_Or_Pm, 1'b1);

    // Hour and minute stepping in set mode
    do_reset();
    set_Mode = 1'b1;
    @(negedge clk);
    repeat (11) pulse(1'b1, 1'b0);
    check_eq("hstep_1100", hhmm, 16'h1100);
    check_eq("hstep_am", am_Or_Pm, 1'b0);
    pulse(1'b1, 1'b0);
    check_eq("hstep_1200", hhmm, 16'h1200);
    check_eq("hstep_pm", am_Or_Pm, 1'b1);
    repeat (59) pulse(1'b0, 1'b1);
    check_eq("mstep_1259", hhmm, 16'h1259);
    pulse(1'b0, 1'b1);
    check_eq("mstep_wrap", hhmm, 16'h1200);
    check_eq("mstep_pm", am_Or_Pm, 1'b1);

    // Simultaneous pulses at 12:59
    repeat (59) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    check_eq("both_0100", hhmm, 16'h0100);
    check_eq("both_pm", am_Or_Pm, 1'b1);
    check_eq("set_no_tick", set_tick_cnt, 0);

    // Asynchronous reset at 03:47 PM
    repeat (2) pulse(1'b1, 1'b0);
    repeat (47) pulse(1'b0, 1'b1);
    set_Mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("run_0347", hhmm, 16'h0347);
    check_eq("run_0347_pm", am_Or_Pm, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_time", hhmm, 16'h1200);
    check_eq("async_pm", am_Or_Pm, 1'b0);
    check_eq("async_tick", second_Tick, 1'b0);
    check_eq("async_disp", display_On, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    first_tick(cyc);
    check_eq("post_async_tick_cyc", cyc, 10);

    // Display enable behaviour in set mode
    do_reset();
    set_Mode = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      disp_hist[k] = display_On;
    end
`ifdef SET_BLINK_EN
    check_eq("blink_k4", disp_hist[4], 1'b1);
    check_eq("blink_k5", disp_hist[5], 1'b0);
    check_eq("blink_k9", disp_hist[9], 1'b0);
    check_eq("blink_k10", disp_hist[10], 1'b1);
    check_eq("blink_k15", disp_hist[15], 1'b0);
`else
    for (int k = 1; k <= 15; k++) check_eq("disp_const", disp_hist[k], 1'b1);
`endif
    pulse(1'b0, 1'b1);
    check_eq("disp_after_inc", display_On, 1'b1);
    check_eq("time_after_inc", hhmm, 16'h1201);
    set_Mode = 1'b0;
    @(negedge clk);
    check_eq("disp_normal", display_On, 1'b1);
    check_eq("set_no_tick_final", set_tick_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
